// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the mul_sched multiplier sequencer.
package mul_sched_pkg;

    localparam int unsigned DefaultW = 32;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StResp
    } state_e;

endpackage

// File: rtl/mul_sched_arb.sv
// Two-way round-robin arbiter; purely combinational, the history bit lives in the caller.
module rr_arb2
    import mul_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = enable & (|req);
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = REQ1;
        end else begin
            grant = REQ0;
        end
    end

endmodule

// File: rtl/mul_sched.sv
// Shares one multi-cycle shift-add multiplier between two requesters: round-robin grant,
// W datapath steps, then a held valid/ready response to the owner.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned W = DefaultW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     req_ready,
    output logic           dp_load,
    output logic [W-1:0]   dp_a,
    output logic [W-1:0]   dp_b,
    output logic           dp_step,
    input  logic [2*W-1:0] dp_product,
    output logic [1:0]     rsp_valid,
    output logic [2*W-1:0] rsp_product,
    input  logic [1:0]     rsp_ready,
    output logic           busy,
    output logic           owner
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LastCount = CW'(W - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q;
    logic             owner_q;
    logic             last_grant_q;
    logic [W-1:0]     dp_a_q, dp_b_q;
    logic [2*W-1:0]   rsp_product_q;
    logic             arb_en;
    logic             grant;
    logic             grant_valid;

    assign arb_en = (state_q == StIdle);

    rr_arb2 u_arb (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .enable      (arb_en),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_valid) state_d = StLoad;
            StLoad:  state_d = StRun;
            StRun:   if (count_q == LastCount) state_d = StDrain;
            StDrain: state_d = StResp;
            StResp:  if (rsp_ready[owner_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            owner_q       <= REQ0;
            last_grant_q  <= REQ1;
            dp_a_q        <= '0;
            dp_b_q        <= '0;
            rsp_product_q <= '0;
        end else begin
            if (grant_valid) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                dp_a_q       <= grant ? req_a[2*W-1:W] : req_a[W-1:0];
                dp_b_q       <= grant ? req_b[2*W-1:W] : req_b[W-1:0];
            end
            if (state_q == StLoad) begin
                count_q <= '0;
            end else if (state_q == StRun && count_q != LastCount) begin
                count_q <= count_q + 1'b1;
            end
            // Datapath product is valid in the cycle after the final step.
            if (state_q == StDrain) begin
                rsp_product_q <= dp_product;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        dp_load   = 1'b0;
        dp_step   = 1'b0;
        busy      = (state_q != StIdle);
        unique case (state_q)
            StLoad: begin
                dp_load            = 1'b1;
                req_ready[owner_q] = 1'b1;
            end
            StRun:   dp_step = 1'b1;
            StResp:  rsp_valid[owner_q] = 1'b1;
            default: ;
        endcase
    end

    assign dp_a        = dp_a_q;
    assign dp_b        = dp_b_q;
    assign rsp_product = rsp_product_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural shift-add datapath and a response scoreboard.
module tb_mul_sched;
    import mul_sched_pkg::*;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     req_valid = '0;
    logic [2*W-1:0] req_a = '0;
    logic [2*W-1:0] req_b = '0;
    logic [1:0]     req_ready;
    logic           dp_load;
    logic [W-1:0]   dp_a, dp_b;
    logic           dp_step;
    logic [2*W-1:0] dp_product;
    logic [1:0]     rsp_valid;
    logic [2*W-1:0] rsp_product;
    logic [1:0]     rsp_ready = 2'b11;
    logic           busy;
    logic           owner;

    mul_sched #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .dp_load     (dp_load),
        .dp_a        (dp_a),
        .dp_b        (dp_b),
        .dp_step     (dp_step),
        .dp_product  (dp_product),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_ready   (rsp_ready),
        .busy        (busy),
        .owner       (owner)
    );

    always #5 clk = ~clk;

    // Behavioural shift-add multiplier: one partial product per step.
    logic [2*W-1:0] mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic [2*W-1:0] acc = '0;
    int             step_cnt = 0;

    always @(posedge clk) begin
        if (dp_load) begin
            mcand    <= {{W{1'b0}}, dp_a};
            mplier   <= dp_b;
            acc      <= '0;
            step_cnt <= 0;
        end else if (dp_step) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            step_cnt <= step_cnt + 1;
        end
    end
    assign dp_product = acc;

    typedef struct {
        logic           idx;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t           sb[$];
    logic [2*W-1:0] last_prod;
    int             vectors = 0;
    int             miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    task automatic drive_req(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[idx]     = 1'b1;
        req_a[idx*W +: W]  = a;
        req_b[idx*W +: W]  = b;
    endtask

    task automatic push(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.idx  = idx;
        e.prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        sb.push_back(e);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n++;
            if (req_ready != 2'b00) break;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (rsp_valid != 2'b00) break;
        end
    endtask

    // Waits for a response and compares it with the oldest scoreboard entry.
    task automatic expect_rsp(input string tag, input int lat_exp);
        int   n;
        exp_t e;
        wait_rsp(n);
        if (sb.size() == 0) begin
            e.idx  = 1'b0;
            e.prod = '0;
        end else begin
            e = sb.pop_front();
        end
        last_prod = e.prod;
        check({tag, "_valid"}, 64'(rsp_valid), 64'(onehot(e.idx)));
        check({tag, "_product"}, rsp_product, e.prod);
        check({tag, "_latency"}, 64'(n), 64'(lat_exp));
    endtask

    task automatic single_job(input string tag, input logic idx,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        drive_req(idx, a, b);
        push(idx, a, b);
        wait_ready(n);
        check({tag, "_ready"}, 64'(req_ready), 64'(onehot(idx)));
        check({tag, "_ready_lat"}, 64'(n), 64'd1);
        check({tag, "_dp_a"}, 64'(dp_a), 64'(a));
        check({tag, "_dp_b"}, 64'(dp_b), 64'(b));
        check({tag, "_owner"}, 64'(owner), 64'(idx));
        req_valid[idx] = 1'b0;
        expect_rsp(tag, W + 2);
        check({tag, "_steps"}, 64'(step_cnt), 64'(W));
        check({tag, "_step_off"}, 64'(dp_step), 64'd0);
        tick();
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        int stray;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'($urandom);
            req_a     = {$urandom, $urandom};
            req_b     = {$urandom, $urandom};
            rsp_ready = 2'($urandom);
            tick();
            check("rst_ctrl", 64'({req_ready, dp_load, dp_step, rsp_valid, busy, owner}), 64'd0);
            check("rst_dp_a", 64'(dp_a), 64'd0);
            check("rst_dp_b", 64'(dp_b), 64'd0);
            check("rst_product", rsp_product, 64'd0);
        end
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b11;
        tick();
        tick();
        check("post_rst_idle", 64'({req_ready, dp_load, dp_step, rsp_valid, busy}), 64'd0);

        // Single requests, including extreme operands
        single_job("single", REQ0, 32'd6, 32'd7);
        single_job("ext_ones", REQ0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("ext_ones_const", last_prod, 64'hFFFF_FFFE_0000_0001);
        single_job("ext_zero", REQ1, 32'd0, 32'h1234_5678);

        // Tie: both requesters held valid, grants must alternate starting with 0
        drive_req(REQ0, 32'd3, 32'd5);
        drive_req(REQ1, 32'd11, 32'd13);
        for (int j = 0; j < 4; j++) begin
            logic exp_idx;
            exp_idx = (j % 2 == 1);
            push(exp_idx, exp_idx ? 32'd11 : 32'd3, exp_idx ? 32'd13 : 32'd5);
            wait_ready(n);
            check("tie_ready", 64'(req_ready), 64'(onehot(exp_idx)));
            check("tie_bubble", 64'(n), (j == 0) ? 64'd1 : 64'd2);
            expect_rsp("tie", W + 2);
        end
        req_valid = '0;
        tick();
        check("tie_idle", 64'(busy), 64'd0);

        // Backpressure on requester 0 while requester 1 waits
        rsp_ready = 2'b10;
        drive_req(REQ0, 32'd100, 32'd200);
        push(REQ0, 32'd100, 32'd200);
        wait_ready(n);
        check("bp_ready0", 64'(req_ready), 64'b01);
        req_valid[0] = 1'b0;
        drive_req(REQ1, 32'd9, 32'd9);
        push(REQ1, 32'd9, 32'd9);
        expect_rsp("bp0", W + 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 64'(rsp_valid), 64'b01);
            check("bp_hold_product", rsp_product, last_prod);
            check("bp_no_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 2'b11;
        wait_ready(n);
        check("bp_ready1", 64'(req_ready), 64'b10);
        check("bp_bubble", 64'(n), 64'd2);
        req_valid = '0;
        expect_rsp("bp1", W + 2);
        tick();

        // Reset in the middle of RUN
        drive_req(REQ0, 32'd5, 32'd5);
        push(REQ0, 32'd5, 32'd5);
        wait_ready(n);
        check("mid_ready", 64'(req_ready), 64'b01);
        req_valid = '0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_running", 64'(dp_step), 64'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_state", 64'({busy, dp_step, rsp_valid, owner}), 64'd0);
        rst = 1'b0;
        void'(sb.pop_back());
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid != 2'b00 || busy) stray++;
        end
        check("mid_no_rsp", 64'(stray), 64'd0);
        drive_req(REQ0, 32'd21, 32'd2);
        drive_req(REQ1, 32'd4, 32'd4);
        push(REQ0, 32'd21, 32'd2);
        wait_ready(n);
        check("mid_tie_ready", 64'(req_ready), 64'b01);
        req_valid = '0;
        expect_rsp("mid_tie", W + 2);
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
